// File: rtl/press_charge_if.sv
// Button/jump-stage bundle for press_charge: stimulus inputs plus the
// length/tall/enable outputs handed to the jump stage.
interface press_charge_if;
  logic       btn;
  logic       pulse;
  logic       jump_fin;
  logic [9:0] length;
  logic [9:0] tall;
  logic       jump_en;
  logic       charging;
  logic       land;

  modport master (
    output btn, pulse, jump_fin,
    input  length, tall, jump_en, charging, land
  );

  modport slave (
    input  btn, pulse, jump_fin,
    output length, tall, jump_en, charging, land
  );
endinterface

// File: rtl/press_charge.sv
// Jump-stage upstream controller: debounces the button, charges length/tall per
// frame tick, drives jump_en and rearms on jump_fin. Optional: AUTO_RELEASE_EN.
module press_charge #(
  parameter int unsigned TALL_MAX  = 80,
  parameter int unsigned TALL_MIN  = 40,
  parameter int unsigned TALL_STEP = 1,
  parameter int unsigned LEN_MIN   = 40,
  parameter int unsigned LEN_MAX   = 600,
  parameter int unsigned LEN_STEP  = 4,
  parameter int unsigned DEB_TICKS = 3
) (
  input logic           clk,
  input logic           rst,
  press_charge_if.slave bus
);

  localparam int unsigned DW = $clog2(DEB_TICKS + 1);

  typedef enum logic [1:0] {IDLE, CHARGE, JUMP, LAND} state_e;

  state_e          state_q, state_d;
  logic            btn_s1_q, btn_s1_d;
  logic            btn_s2_q, btn_s2_d;
  logic            btn_d_q, btn_d_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [9:0]      length_q, length_d;
  logic [9:0]      tall_q, tall_d;
  logic            jump_en_q, jump_en_d;
  logic            charging_q, charging_d;
  logic            land_q, land_d;

  logic            press, rel;
  logic [10:0]     len_sum;
  logic [9:0]      len_sat;
  logic [9:0]      tall_sat;

  always_comb begin
    btn_s1_d  = bus.btn;
    btn_s2_d  = btn_s1_q;
    btn_d_d   = btn_d_q;
    deb_cnt_d = deb_cnt_q;

    // Debounce state only advances on frame ticks; any agreeing sample restarts the count.
    if (bus.pulse) begin
      if (btn_s2_q != btn_d_q) begin
        if (deb_cnt_q == DW'(DEB_TICKS - 1)) begin
          btn_d_d   = btn_s2_q;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end else begin
        deb_cnt_d = '0;
      end
    end

    press = btn_d_d & ~btn_d_q;
    rel   = ~btn_d_d & btn_d_q;

    len_sum = {1'b0, length_q} + 11'(LEN_STEP);
    len_sat = (len_sum > 11'(LEN_MAX)) ? 10'(LEN_MAX) : len_sum[9:0];
    tall_sat = ({1'b0, tall_q} < 11'(TALL_MIN + TALL_STEP)) ? 10'(TALL_MIN)
                                                            : tall_q - 10'(TALL_STEP);

    state_d   = state_q;
    length_d  = length_q;
    tall_d    = tall_q;
    jump_en_d = 1'b0;
    land_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (press) begin
          state_d  = CHARGE;
          length_d = 10'(LEN_MIN);
          tall_d   = 10'(TALL_MAX);
        end
      end
      CHARGE: begin
        if (rel) begin
          state_d = JUMP;
        end else if (bus.pulse && btn_d_q) begin
          length_d = len_sat;
          tall_d   = tall_sat;
`ifdef AUTO_RELEASE_EN
          if (len_sat == 10'(LEN_MAX)) state_d = JUMP;
`endif
        end
      end
      JUMP: begin
        if (bus.jump_fin) begin
          state_d = LAND;
          land_d  = 1'b1;
          tall_d  = 10'(TALL_MAX);
        end else begin
          jump_en_d = 1'b1;
        end
      end
      LAND: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    charging_d = (state_d == CHARGE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_d_q    <= 1'b0;
      deb_cnt_q  <= '0;
      length_q   <= 10'(LEN_MIN);
      tall_q     <= 10'(TALL_MAX);
      jump_en_q  <= 1'b0;
      charging_q <= 1'b0;
      land_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      btn_d_q    <= btn_d_d;
      deb_cnt_q  <= deb_cnt_d;
      length_q   <= length_d;
      tall_q     <= tall_d;
      jump_en_q  <= jump_en_d;
      charging_q <= charging_d;
      land_q     <= land_d;
    end
  end

  assign bus.length   = length_q;
  assign bus.tall     = tall_q;
  assign bus.jump_en  = jump_en_q;
  assign bus.charging = charging_q;
  assign bus.land     = land_q;

endmodule

// File: tb/tb_press_charge.sv
// Self-checking bench for press_charge; expected jump parameters are queued at
// release time and compared when jump_en rises. Honours AUTO_RELEASE_EN.
module tb_press_charge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  press_charge_if bus ();

  press_charge #(
    .TALL_MAX (80),
    .TALL_MIN (40),
    .TALL_STEP(1),
    .LEN_MIN  (40),
    .LEN_MAX  (600),
    .LEN_STEP (4),
    .DEB_TICKS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [9:0] len;
    logic [9:0] tall;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_exp;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   land_cnt  = 0;
  logic jen_prev  = 1'b0;

  // n = number of increment ticks applied during the charge
  function automatic exp_t model(input int n);
    exp_t e;
    int   l, t;
    l = 40 + 4 * n;
    t = 80 - n;
    if (l > 600) l = 600;
    if (t < 40) t = 40;
    e.len  = 10'(l);
    e.tall = 10'(t);
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.jump_en === 1'b1 && jen_prev !== 1'b1) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL jump_start unexpected: length=%0d tall=%0d", bus.length, bus.tall);
      end else begin
        cur_exp = exp_q.pop_front();
        if ({bus.length, bus.tall} !== {cur_exp.len, cur_exp.tall})
          $display("FAIL jump_start: length=%0d tall=%0d expected length=%0d tall=%0d",
                   bus.length, bus.tall, cur_exp.len, cur_exp.tall);
        else pass_cnt++;
      end
    end else if (bus.jump_en === 1'b1) begin
      total_cnt++;
      if ({bus.length, bus.tall} !== {cur_exp.len, cur_exp.tall})
        $display("FAIL jump_hold: length=%0d tall=%0d expected length=%0d tall=%0d",
                 bus.length, bus.tall, cur_exp.len, cur_exp.tall);
      else pass_cnt++;
    end
    if (bus.land === 1'b1) begin
      land_cnt++;
      total_cnt++;
      if ({bus.tall, bus.jump_en} !== {10'd80, 1'b0})
        $display("FAIL land_out: tall=%0d jump_en=%b expected tall=80 jump_en=0",
                 bus.tall, bus.jump_en);
      else pass_cnt++;
    end
    jen_prev = bus.jump_en;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Two idle cycles let btn cross the synchroniser before the tick samples it.
  task automatic tick();
    cyc();
    cyc();
    bus.pulse = 1'b1;
    cyc();
    bus.pulse = 1'b0;
  endtask

  task automatic wait_charging(input logic val, input int max_ticks, output int n);
    n = 0;
    while (bus.charging !== val && n < max_ticks) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_fin();
    bus.jump_fin = 1'b1;
    cyc();
    bus.jump_fin = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.btn = 1'b0;
    bus.pulse = 1'b0;
    bus.jump_fin = 1'b0;
    cyc();
    cyc();
    total_cnt++;
    if ({bus.length, bus.tall, bus.jump_en, bus.land, bus.charging} !== {10'd40, 10'd80, 3'b000})
      $display("FAIL reset: length=%0d tall=%0d jen=%b land=%b chg=%b expected 40 80 0 0 0",
               bus.length, bus.tall, bus.jump_en, bus.land, bus.charging);
    else pass_cnt++;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_glitch();
    bus.btn = 1'b1;
    tick();
    tick();
    bus.btn = 1'b0;
    repeat (4) tick();
    total_cnt++;
    if ({bus.charging, bus.jump_en, bus.length, bus.tall} !== {2'b00, 10'd40, 10'd80})
      $display("FAIL glitch: chg=%b jen=%b length=%0d tall=%0d expected 0 0 40 80",
               bus.charging, bus.jump_en, bus.length, bus.tall);
    else pass_cnt++;
  endtask

  task automatic test_charge();
    int n;
    bus.btn = 1'b1;
    wait_charging(1'b1, 10, n);
    total_cnt++;
    if (n !== 3) $display("FAIL press_latency: ticks=%0d expected 3", n);
    else pass_cnt++;
    repeat (8) tick();
    total_cnt++;
    if ({bus.length, bus.tall} !== {10'd72, 10'd72})
      $display("FAIL mid_charge: length=%0d tall=%0d expected 72 72", bus.length, bus.tall);
    else pass_cnt++;
    bus.btn = 1'b0;
    exp_q.push_back(model(10));
    wait_charging(1'b0, 10, n);
    total_cnt++;
    if (n !== 3) $display("FAIL release_latency: ticks=%0d expected 3", n);
    else pass_cnt++;
    total_cnt++;
    if (bus.jump_en !== 1'b0) $display("FAIL jen_delay: jump_en=%b expected 0", bus.jump_en);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (bus.jump_en !== 1'b1) $display("FAIL jen_rise: jump_en=%b expected 1", bus.jump_en);
    else pass_cnt++;
    repeat (3) tick();
    pulse_fin();
    total_cnt++;
    if ({bus.land, bus.tall, bus.jump_en} !== {1'b1, 10'd80, 1'b0})
      $display("FAIL land_cycle: land=%b tall=%0d jen=%b expected 1 80 0",
               bus.land, bus.tall, bus.jump_en);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (bus.land !== 1'b0) $display("FAIL land_width: land=%b expected 0", bus.land);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    int n;
    bus.btn = 1'b1;
    wait_charging(1'b1, 10, n);
`ifdef AUTO_RELEASE_EN
    exp_q.push_back(model(140));
    wait_charging(1'b0, 300, n);
    total_cnt++;
    if (n !== 140) $display("FAIL auto_release: ticks=%0d expected 140", n);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (bus.jump_en !== 1'b1) $display("FAIL sat_jen: jump_en=%b expected 1", bus.jump_en);
    else pass_cnt++;
    bus.btn = 1'b0;
    repeat (4) tick();
`else
    repeat (198) tick();
    total_cnt++;
    if ({bus.length, bus.tall, bus.charging} !== {10'd600, 10'd40, 1'b1})
      $display("FAIL saturate: length=%0d tall=%0d chg=%b expected 600 40 1",
               bus.length, bus.tall, bus.charging);
    else pass_cnt++;
    bus.btn = 1'b0;
    exp_q.push_back(model(200));
    wait_charging(1'b0, 10, n);
    cyc();
    total_cnt++;
    if (bus.jump_en !== 1'b1) $display("FAIL sat_jen: jump_en=%b expected 1", bus.jump_en);
    else pass_cnt++;
`endif
    pulse_fin();
    cyc();
  endtask

  task automatic test_hold_rearm();
    int n;
    int lc;
    bus.btn = 1'b1;
    wait_charging(1'b1, 10, n);
    repeat (5) tick();
    bus.btn = 1'b0;
    exp_q.push_back(model(7));
    wait_charging(1'b0, 10, n);
    bus.btn = 1'b1;
    repeat (5) tick();
    total_cnt++;
    if ({bus.charging, bus.jump_en} !== 2'b01)
      $display("FAIL jump_ignores_btn: chg=%b jen=%b expected 0 1", bus.charging, bus.jump_en);
    else pass_cnt++;
    lc = land_cnt;
    pulse_fin();
    cyc();
    repeat (5) tick();
    total_cnt++;
    if ({bus.charging, land_cnt} !== {1'b0, lc + 1})
      $display("FAIL held_no_rearm: chg=%b lands=%0d expected 0 %0d", bus.charging, land_cnt, lc + 1);
    else pass_cnt++;
    bus.btn = 1'b0;
    repeat (4) tick();
    bus.btn = 1'b1;
    wait_charging(1'b1, 10, n);
    total_cnt++;
    if (n !== 3) $display("FAIL fresh_press: ticks=%0d expected 3", n);
    else pass_cnt++;
    bus.btn = 1'b0;
    exp_q.push_back(model(2));
    wait_charging(1'b0, 10, n);
    cyc();
    pulse_fin();
    cyc();
  endtask

  task automatic test_reset_mid_jump();
    int n;
    int lc;
    bus.btn = 1'b1;
    wait_charging(1'b1, 10, n);
    bus.btn = 1'b0;
    exp_q.push_back(model(2));
    wait_charging(1'b0, 10, n);
    cyc();
    total_cnt++;
    if (bus.jump_en !== 1'b1) $display("FAIL pre_abort_jen: jump_en=%b expected 1", bus.jump_en);
    else pass_cnt++;
    lc = land_cnt;
    rst = 1'b1;
    cyc();
    total_cnt++;
    if ({bus.jump_en, bus.land, bus.charging, bus.length, bus.tall} !== {3'b000, 10'd40, 10'd80})
      $display("FAIL abort: jen=%b land=%b chg=%b length=%0d tall=%0d expected 0 0 0 40 80",
               bus.jump_en, bus.land, bus.charging, bus.length, bus.tall);
    else pass_cnt++;
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
    pulse_fin();
    repeat (3) cyc();
    total_cnt++;
    if ({land_cnt, bus.jump_en, bus.charging} !== {lc, 2'b00})
      $display("FAIL idle_fin_ignored: lands=%0d jen=%b chg=%b expected %0d 0 0",
               land_cnt, bus.jump_en, bus.charging, lc);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_charge();
    test_saturate();
    test_hold_rearm();
    test_reset_mid_jump();
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: pending=%0d expected 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1);
  end

endmodule
